// File: rtl/param_szamologep_if.sv
// Request/result bundle of the sequential calculator.
// The calculator side uses the slave modport.
interface param_szamologep_if #(
    parameter int W      = 4,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [3:0]            muvelet;
    logic [W-1:0]          op_a;
    logic [W-1:0]          op_b;
    logic                  busy;
    logic                  done;
    logic [2*W-1:0]        result;
    logic [W-1:0]          rem;
    logic                  neg;
    logic                  err;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start, muvelet, op_a, op_b,
        input  busy, done, result, rem, neg, err, bcd
    );

    modport slave (
        input  start, muvelet, op_a, op_b,
        output busy, done, result, rem, neg, err, bcd
    );
endinterface

// File: rtl/param_szamologep.sv
// Sequential ADD/SUB/MUL/DIV calculator with restoring divider
// and shift-add-3 binary to packed BCD conversion.
module param_szamologep #(
    parameter int W      = 4,
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    param_szamologep_if.slave    bus
);
    localparam int RW = 2 * W;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(RW);

    typedef enum logic [2:0] {IDLE, CALC, DIV, BCD, DONE} state_t;

    state_t state, state_nx;

    logic [W-1:0]  a_q, b_q;
    logic [3:0]    op_q;
    logic [RW-1:0] res_q;
    logic [W-1:0]  rem_q;
    logic          neg_q, err_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rmd, quo;
    logic [RW-1:0] bin;
    logic [BW-1:0] bcd_q;

    logic [RW-1:0] result_r;
    logic [W-1:0]  rem_r;
    logic          neg_r, err_r;
    logic [BW-1:0] bcd_r;

    logic          op_ok, accept;
    logic [RW-1:0] calc_res;
    logic          calc_neg, calc_err, div_go;
    logic [W:0]    rmd_sh;
    logic          div_fit;
    logic [W-1:0]  div_r, div_q;
    logic [BW-1:0] dd_adj, dd_nx;
    logic          div_last, bcd_last;

    assign op_ok  = (bus.muvelet != 4'd0) &&
                    ((bus.muvelet & (bus.muvelet - 4'd1)) == 4'd0);
    assign accept = (state == IDLE) && bus.start && op_ok;

    assign div_last = (cnt == CW'(W - 1));
    assign bcd_last = (cnt == CW'(RW - 1));

    always_comb begin
        calc_res = '0;
        calc_neg = 1'b0;
        calc_err = 1'b0;
        div_go   = 1'b0;
        unique case (1'b1)
            op_q[0]: calc_res = RW'(a_q) + RW'(b_q);
            op_q[1]: begin
                if (a_q >= b_q) begin
                    calc_res = RW'(a_q - b_q);
                end else begin
                    calc_res = RW'(b_q - a_q);
                    calc_neg = 1'b1;
                end
            end
            op_q[2]: calc_res = RW'(a_q) * RW'(b_q);
            op_q[3]: begin
                if (b_q == '0) calc_err = 1'b1;
                else           div_go   = 1'b1;
            end
            default: ;
        endcase
    end

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        rmd_sh  = {rmd, quo[W-1]};
        div_fit = (rmd_sh >= {1'b0, b_q});
        div_r   = div_fit ? W'(rmd_sh - {1'b0, b_q}) : rmd_sh[W-1:0];
        div_q   = {quo[W-2:0], div_fit};
    end

    always_comb begin
        dd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dd_adj[4*i +: 4] >= 4'd5)
                dd_adj[4*i +: 4] = dd_adj[4*i +: 4] + 4'd3;
        end
        dd_nx = (dd_adj << 1) | BW'(bin[RW-1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    state_nx = div_go ? DIV : BCD;
            DIV:     if (div_last) state_nx = BCD;
            BCD:     if (bcd_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            res_q    <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= '0;
            rmd      <= '0;
            quo      <= '0;
            bin      <= '0;
            bcd_q    <= '0;
            result_r <= '0;
            rem_r    <= '0;
            neg_r    <= 1'b0;
            err_r    <= 1'b0;
            bcd_r    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q  <= bus.op_a;
                        b_q  <= bus.op_b;
                        op_q <= bus.muvelet;
                    end
                end
                CALC: begin
                    res_q <= calc_res;
                    rem_q <= '0;
                    neg_q <= calc_neg;
                    err_q <= calc_err;
                    bin   <= calc_res;
                    bcd_q <= '0;
                    cnt   <= '0;
                    rmd   <= '0;
                    quo   <= a_q;
                end
                DIV: begin
                    rmd <= div_r;
                    quo <= div_q;
                    cnt <= cnt + CW'(1);
                    if (div_last) begin
                        res_q <= RW'(div_q);
                        rem_q <= div_r;
                        bin   <= RW'(div_q);
                        cnt   <= '0;
                    end
                end
                BCD: begin
                    bin   <= bin << 1;
                    bcd_q <= dd_nx;
                    cnt   <= cnt + CW'(1);
                    // Final shift lands straight in the visible registers.
                    if (bcd_last) begin
                        result_r <= res_q;
                        rem_r    <= rem_q;
                        neg_r    <= neg_q;
                        err_r    <= err_q;
                        bcd_r    <= dd_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == CALC) || (state == DIV) || (state == BCD);
    assign bus.done   = (state == DONE);
    assign bus.result = result_r;
    assign bus.rem    = rem_r;
    assign bus.neg    = neg_r;
    assign bus.err    = err_r;
    assign bus.bcd    = bcd_r;
endmodule
